linear32_stream: RTL and testbench

Streaming wrapper around the existing linear32 GF(2) matrix-vector unit. It loads the 32x32 bit matrix one 32-bit row per handshake, then accepts 32-bit input vectors and returns y = M·a over GF(2), where y[i] = XOR-reduce(a & row i). Output is registered and flow-controlled. It sits between the NLU configuration/data feeder (upstream) and the next NLU stage (downstream).

---
 rtl/linear32_pkg.sv | 17 +
 rtl/linear32_stream_if.sv | 27 ++
 rtl/linear32.sv | 17 +
 rtl/linear32_stream.sv | 95 +++++++++
 tb/tb_linear32_stream.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/linear32_pkg.sv
// Shared widths, FSM states and row-order encodings for the linear32 streaming wrapper.
package linear32_pkg;

    localparam int VEC_W = 32;
    localparam int ROWS  = 32;
    localparam int MAT_W = VEC_W * ROWS;

    localparam int ROW_ORDER_FWD = 0;
    localparam int ROW_ORDER_REV = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/linear32_stream_if.sv
// Handshake bundle for the matrix-load, input-vector and result streams.
interface linear32_stream_if;
    import linear32_pkg::*;

    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [VEC_W-1:0] cfg_row;
    logic             mat_valid;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_row, in_valid, in_data, out_ready,
        input  cfg_ready, mat_valid, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_row, in_valid, in_data, out_ready,
        output cfg_ready, mat_valid, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/linear32.sv
// Combinational GF(2) matrix-vector product: y[i] = XOR-reduce(a & row i), row i = m[32i+31:32i].
module linear32
    import linear32_pkg::*;
(
    input  logic [MAT_W-1:0] m,
    input  logic [VEC_W-1:0] a,
    output logic [VEC_W-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < ROWS; i++) begin
            y[i] = ^(a & m[i*VEC_W +: VEC_W]);
        end
    end

endmodule

// File: rtl/linear32_stream.sv
// Streaming wrapper: loads a 32x32 GF(2) matrix row by row, then returns registered
// y = M*a for each accepted input vector under valid/ready flow control.
module linear32_stream
    import linear32_pkg::*;
#(
    parameter int ROW_ORDER = ROW_ORDER_FWD
) (
    input logic              clk,
    input logic              rst,
    linear32_stream_if.slave bus
);

    state_t           state_q, state_d;
    logic [4:0]       row_cnt_q, row_cnt_d;
    logic [MAT_W-1:0] mat_q, mat_d;
    logic             mat_valid_q, mat_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [VEC_W-1:0] out_data_q, out_data_d;

    logic [VEC_W-1:0] y;
    logic [4:0]       row_idx;
    logic             cfg_ready, in_ready, cfg_fire, in_fire;

    // Reverse order stores the k-th row at index 31-k, which is the bitwise inverse of k.
    assign row_idx   = (ROW_ORDER == ROW_ORDER_REV) ? ~row_cnt_q : row_cnt_q;
    assign cfg_ready = (state_q == LOAD);
    assign in_ready  = (state_q == READY) && (!out_valid_q || bus.out_ready);
    assign cfg_fire  = bus.cfg_valid && cfg_ready;
    assign in_fire   = bus.in_valid && in_ready;

    assign bus.cfg_ready = cfg_ready;
    assign bus.in_ready  = in_ready;
    assign bus.mat_valid = mat_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    linear32 u_linear32 (
        .m (mat_q),
        .a (bus.in_data),
        .y (y)
    );

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        mat_d       = mat_q;
        mat_valid_d = mat_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // A restart beats a row transfer in the same cycle; that row is dropped.
        if (bus.cfg_start) begin
            state_d     = LOAD;
            row_cnt_d   = '0;
            mat_valid_d = 1'b0;
        end else if (cfg_fire) begin
            mat_d[int'(row_idx)*VEC_W +: VEC_W] = bus.cfg_row;
            row_cnt_d = row_cnt_q + 5'd1;
            if (row_cnt_q == 5'(ROWS - 1)) begin
                state_d     = READY;
                mat_valid_d = 1'b1;
                row_cnt_d   = '0;
            end
        end

        // The product uses mat_q, so an input taken alongside cfg_start sees the old matrix.
        if (in_fire) begin
            out_data_d  = y;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            row_cnt_q   <= '0;
            // NOTE: the matrix store is deliberately reset so a result can never expose stale rows after reset.
            mat_q       <= '0;
            mat_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            mat_q       <= mat_d;
            mat_valid_q <= mat_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_linear32_stream.sv
// Bench for linear32_stream: both row orders run side by side against a row-list reference model.
module tb_linear32_stream;
    import linear32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_valid, in_valid, out_ready;
    logic [31:0] cfg_row, in_data;

    always #5 clk = ~clk;

    linear32_stream_if if0 ();
    linear32_stream_if if1 ();

    assign if0.cfg_start = cfg_start;
    assign if0.cfg_valid = cfg_valid;
    assign if0.cfg_row   = cfg_row;
    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if1.cfg_start = cfg_start;
    assign if1.cfg_valid = cfg_valid;
    assign if1.cfg_row   = cfg_row;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;

    linear32_stream #(.ROW_ORDER(ROW_ORDER_FWD)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    linear32_stream #(.ROW_ORDER(ROW_ORDER_REV)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: rows kept in acceptance order, matrix applied by parity counting.
    bit          m_loading, m_have, m_pend;
    int          m_cnt;
    logic [31:0] m_rows [32];
    logic [31:0] m_out0, m_out1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] y0;
        logic [31:0] y1;
    } vec_t;

    vec_t        ident_tbl [5];
    vec_t        ones_tbl  [6];
    logic [31:0] rows_ident [32];
    logic [31:0] rows_ones  [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] gf_apply(input logic [31:0] rows [32], input bit rev,
                                             input logic [31:0] a);
        logic [31:0] r;
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            r    = rev ? rows[31-i] : rows[i];
            y[i] = ($countones(a & r) % 2) == 1;
        end
        return y;
    endfunction

    task automatic model_clear();
        m_loading = 0;
        m_have    = 0;
        m_pend    = 0;
        m_cnt     = 0;
        m_out0    = '0;
        m_out1    = '0;
        for (int i = 0; i < 32; i++) m_rows[i] = '0;
    endtask

    // Entered just after a rising edge with inputs already driven; returns just after the next edge.
    task automatic cycle();
        bit cf, inf;
        #1;
        check("cfg_ready0", 32'(if0.cfg_ready), 32'(m_loading));
        check("cfg_ready1", 32'(if1.cfg_ready), 32'(m_loading));
        check("in_ready0", 32'(if0.in_ready), 32'(m_have && (!m_pend || out_ready)));
        check("in_ready1", 32'(if1.in_ready), 32'(m_have && (!m_pend || out_ready)));
        cf  = cfg_valid && m_loading;
        inf = in_valid && m_have && (!m_pend || out_ready);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (inf) begin
                m_pend = 1;
                m_out0 = gf_apply(m_rows, 0, in_data);
                m_out1 = gf_apply(m_rows, 1, in_data);
            end else if (out_ready) begin
                m_pend = 0;
            end
            if (cfg_start) begin
                m_loading = 1;
                m_have    = 0;
                m_cnt     = 0;
            end else if (cf) begin
                m_rows[m_cnt] = cfg_row;
                m_cnt++;
                if (m_cnt == 32) begin
                    m_loading = 0;
                    m_have    = 1;
                    m_cnt     = 0;
                end
            end
        end
        #1;
        check("mat_valid0", 32'(if0.mat_valid), 32'(m_have));
        check("mat_valid1", 32'(if1.mat_valid), 32'(m_have));
        check("out_valid0", 32'(if0.out_valid), 32'(m_pend));
        check("out_valid1", 32'(if1.out_valid), 32'(m_pend));
        check("out_data0", if0.out_data, m_out0);
        check("out_data1", if1.out_data, m_out1);
    endtask

    task automatic idle();
        rst       = 0;
        cfg_start = 0;
        cfg_valid = 0;
        in_valid  = 0;
        out_ready = 1;
    endtask

    task automatic load(input logic [31:0] rows [32]);
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cfg_valid = 1;
        for (int k = 0; k < 32; k++) begin
            cfg_row = rows[k];
            cycle();
            if (k == 30) check("mat_valid_after_31_rows", 32'(if0.mat_valid), 32'd0);
        end
        cfg_valid = 0;
        check("mat_valid_after_32_rows", 32'(if0.mat_valid), 32'd1);
    endtask

    task automatic run_table(input vec_t tbl [], input string name);
        out_ready = 1;
        in_valid  = 1;
        foreach (tbl[i]) begin
            in_data = tbl[i].a;
            cycle();
            check({name, "_y0"}, if0.out_data, tbl[i].y0);
            check({name, "_y1"}, if1.out_data, tbl[i].y1);
            check({name, "_valid"}, 32'(if0.out_valid), 32'd1);
        end
        in_valid = 0;
        cycle();
        check({name, "_drain"}, 32'(if0.out_valid), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            rows_ident[k] = 32'd1 << k;
            rows_ones[k]  = 32'hFFFF_FFFF;
        end
        ident_tbl[0] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hF77D_B57B};
        ident_tbl[1] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        ident_tbl[2] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};
        ident_tbl[3] = '{32'h1234_5678, 32'h1234_5678, 32'h1E6A_2C48};
        ident_tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        ones_tbl[0]  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ones_tbl[1]  = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0000};
        ones_tbl[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ones_tbl[3]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        ones_tbl[4]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ones_tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset with random activity on every input.
        rst       = 1;
        cfg_start = 1'($urandom);
        cfg_valid = 1'($urandom);
        cfg_row   = $urandom;
        in_valid  = 1'($urandom);
        in_data   = $urandom;
        out_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mat_valid", 32'(if0.mat_valid), 32'd0);
        check("rst_cfg_ready", 32'(if0.cfg_ready), 32'd0);
        check("rst_in_ready", 32'(if0.in_ready), 32'd0);
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_out_data", if0.out_data, 32'h0);
        model_clear();
        idle();
        cycle();

        // Identity rows: forward order returns a, reverse order returns bit-reversed a.
        load(rows_ident);
        run_table(ident_tbl, "ident");

        // All-ones rows: every output bit is the parity of a.
        load(rows_ones);
        run_table(ones_tbl, "ones");

        // Backpressure with identity matrix.
        load(rows_ident);
        out_ready = 0;
        in_valid  = 1;
        in_data   = 32'h1;
        cycle();
        in_data = 32'h2;
        cycle();
        check("bp_in_ready_low", 32'(if0.in_ready), 32'd0);
        check("bp_hold_data", if0.out_data, 32'h1);
        out_ready = 1;
        cycle();
        in_valid = 0;
        check("bp_second_result", if0.out_data, 32'h2);
        check("bp_second_valid", 32'(if0.out_valid), 32'd1);
        cycle();

        // Restart after 10 rows: count starts over.
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cfg_valid = 1;
        for (int k = 0; k < 10; k++) begin
            cfg_row = $urandom;
            cycle();
        end
        cfg_valid = 0;
        load(rows_ident);

        // Pending output survives a reload until consumed.
        out_ready = 0;
        in_valid  = 1;
        in_data   = 32'hA5A5_5A5A;
        cycle();
        in_valid  = 0;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cfg_valid = 1;
        for (int k = 0; k < 5; k++) begin
            cfg_row = $urandom;
            cycle();
        end
        check("pend_hold_data", if0.out_data, 32'hA5A5_5A5A);
        check("pend_hold_valid", 32'(if0.out_valid), 32'd1);
        out_ready = 1;
        cycle();
        check("pend_consumed", 32'(if0.out_valid), 32'd0);

        // Reset mid-load clears everything.
        rst = 1;
        cycle();
        rst       = 0;
        cfg_valid = 0;
        check("rst_midload_cfg_ready", 32'(if0.cfg_ready), 32'd0);
        check("rst_midload_mat_valid", 32'(if0.mat_valid), 32'd0);

        // cfg_start in the same cycle as an input: old matrix is used.
        load(rows_ones);
        in_valid  = 1;
        in_data   = 32'h7;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        in_valid  = 0;
        check("start_with_input_y", if0.out_data, 32'hFFFF_FFFF);
        check("start_with_input_load", 32'(if0.cfg_ready), 32'd1);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            cfg_start = ($urandom_range(0, 79) == 0);
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_row   = $urandom;
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
